// File: rtl/stepseq_onehot.sv
// N-state up/down step sequencer with a built-in clock-enable divider,
// synchronous load with range check, wrap detection and a one-hot state decode.
module stepseq_onehot #(
  parameter int N_STATES = 4,
  parameter int DIV      = 50_000_000,
  localparam int SW = (N_STATES > 2) ? $clog2(N_STATES) : 1,
  localparam int DW = (DIV > 2) ? $clog2(DIV) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic                dir,
  input  logic                hold,
  input  logic                load,
  input  logic [SW-1:0]       load_val,
  output logic [SW-1:0]       state,
  output logic [SW-1:0]       state_b,
  output logic [N_STATES-1:0] onehot,
  output logic                tick,
  output logic                wrap,
  output logic                load_err
);

  localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);
  localparam logic [SW-1:0] LAST   = SW'(N_STATES - 1);
  localparam logic [SW:0]   N_EXT  = (SW + 1)'(N_STATES);

  logic [DW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] state_q, state_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;
  logic          load_ok;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q      <= '0;
      state_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    tick       = run & (cnt_q == DIV_M1);
    load_ok    = ({1'b0, load_val} < N_EXT);

    if (run) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Load wins over stepping; a rejected load still blocks a coincident step
    // but leaves the divider running normally.
    if (load) begin
      if (load_ok) begin
        state_d = load_val;
        cnt_d   = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick && !hold) begin
      if (dir) begin
        if (state_q == LAST) begin
          state_d = '0;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q + 1'b1;
        end
      end else begin
        if (state_q == '0) begin
          state_d = LAST;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N_STATES; i++) begin
      onehot[i] = (state_q == SW'(i));
    end
  end

  assign state    = state_q;
  assign state_b  = ~state_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_stepseq_onehot.sv
// Directed bench: 5-state / DIV=3 sequencer plus a 2-state / DIV=1 instance,
// with hand-computed expectations checked at each negedge.
module tb_stepseq_onehot;

  logic       clk = 1'b0;
  logic       clr;
  logic       run, dir, hold, load;
  logic [2:0] load_val;
  logic [2:0] state, state_b;
  logic [4:0] onehot;
  logic       tick, wrap, load_err;

  logic       s2_run, s2_dir, s2_hold, s2_load;
  logic [0:0] s2_load_val;
  logic [0:0] s2_state, s2_state_n;
  logic [1:0] s2_onehot;
  logic       s2_tick, s2_wrap, s2_load_err;

  int n_vec = 0;
  int n_err = 0;

  int up_exp[5] = '{1, 2, 3, 4, 0};
  int dn_exp[5] = '{4, 3, 2, 1, 0};
  int oh_tab[5] = '{1, 2, 4, 8, 16};

  always #5 clk = ~clk;

  stepseq_onehot #(.N_STATES(5), .DIV(3)) u_dut (
    .clk(clk), .clr(clr), .run(run), .dir(dir), .hold(hold), .load(load),
    .load_val(load_val), .state(state), .state_b(state_b), .onehot(onehot),
    .tick(tick), .wrap(wrap), .load_err(load_err)
  );

  stepseq_onehot #(.N_STATES(2), .DIV(1)) u_dut2 (
    .clk(clk), .clr(clr), .run(s2_run), .dir(s2_dir), .hold(s2_hold),
    .load(s2_load), .load_val(s2_load_val), .state(s2_state),
    .state_b(s2_state_n), .onehot(s2_onehot), .tick(s2_tick),
    .wrap(s2_wrap), .load_err(s2_load_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; run = 1'b0; dir = 1'b1; hold = 1'b0; load = 1'b0; load_val = '0;
    s2_run = 1'b0; s2_dir = 1'b1; s2_hold = 1'b0; s2_load = 1'b0; s2_load_val = '0;

    // Reset values, before any clock edge
    #3;
    check("rst_state",   32'(state),    0);
    check("rst_state_b", 32'(state_b),  7);
    check("rst_onehot",  32'(onehot),   1);
    check("rst_tick",    32'(tick),     0);
    check("rst_wrap",    32'(wrap),     0);
    check("rst_lerr",    32'(load_err), 0);
    check("rst_s2",      32'(s2_state), 0);

    // Up count 0,1,2,3,4,0 with a tick every third clk
    @(negedge clk);
    clr = 1'b1; run = 1'b1;
    #1;
    check("up_tick0", 32'(tick), 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      check("up_tick_lo", 32'(tick), 0);
      check("up_wrap_lo", 32'(wrap), 0);
      cyc(1);
      check("up_tick_hi", 32'(tick), 1);
      cyc(1);
      check("up_state",  32'(state),  up_exp[k]);
      check("up_onehot", 32'(onehot), oh_tab[up_exp[k]]);
      check("up_wrap",   32'(wrap),   (k == 4) ? 1 : 0);
    end

    // Down count from 0: 4 (wrap), 3, 2, 1, 0
    dir = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(2);
      check("dn_tick_hi", 32'(tick), 1);
      cyc(1);
      check("dn_state", 32'(state), dn_exp[k]);
      check("dn_wrap",  32'(wrap),  (k == 0) ? 1 : 0);
    end
    check("dn_state_b", 32'(state_b), 7);

    // Hold across two ticks
    hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cyc(2);
      check("hold_tick", 32'(tick), 1);
      cyc(1);
      check("hold_state", 32'(state), 0);
      check("hold_wrap",  32'(wrap),  0);
    end
    hold = 1'b0;

    // run=0 for 10 clks while the tick condition is pending
    dir = 1'b1;
    cyc(2);
    check("run_tick_pre", 32'(tick), 1);
    run = 1'b0;
    #1;
    check("run_tick_off", 32'(tick), 0);
    cyc(10);
    check("run_state_frz", 32'(state), 0);
    check("run_tick_frz",  32'(tick),  0);
    run = 1'b1;
    #1;
    check("run_tick_resume", 32'(tick), 1);
    cyc(1);
    check("run_state_step", 32'(state), 1);
    cyc(3);
    check("step_to_2", 32'(state), 2);

    // Load coincident with a tick: load wins, no step
    cyc(2);
    check("ld_tick", 32'(tick), 1);
    load = 1'b1; load_val = 3'd2;
    cyc(1);
    check("ld_state", 32'(state), 2);
    check("ld_wrap",  32'(wrap),  0);
    load = 1'b0;
    cyc(1);
    check("ld_tick_lo1", 32'(tick), 0);
    cyc(1);
    check("ld_tick_hi", 32'(tick), 1);
    cyc(1);
    check("ld_next_state", 32'(state), 3);

    // Mid-period load clears the divider: full DIV before the next step
    cyc(1);
    load = 1'b1; load_val = 3'd0;
    cyc(1);
    check("ld2_state", 32'(state), 0);
    load = 1'b0;
    cyc(1);
    check("ld2_tick_lo", 32'(tick), 0);
    cyc(1);
    check("ld2_tick_hi", 32'(tick), 1);
    cyc(1);
    check("ld2_next_state", 32'(state), 1);

    // Rejected load: state kept, error pulse, divider unaffected
    cyc(1);
    load = 1'b1; load_val = 3'd6;
    cyc(1);
    check("bad_state", 32'(state),    1);
    check("bad_lerr",  32'(load_err), 1);
    check("bad_tick",  32'(tick),     1);
    load = 1'b0;
    cyc(1);
    check("bad_lerr_lo", 32'(load_err), 0);
    check("bad_step",    32'(state),    2);

    // Rejected load coincident with a tick blocks the step
    cyc(2);
    check("bad2_tick", 32'(tick), 1);
    load = 1'b1; load_val = 3'd7;
    cyc(1);
    check("bad2_state", 32'(state),    2);
    check("bad2_lerr",  32'(load_err), 1);
    load = 1'b0;
    cyc(1);
    check("bad2_lerr_lo", 32'(load_err), 0);
    check("bad2_tick_lo", 32'(tick),     0);

    // Load with run=0 still applies
    run = 1'b0; load = 1'b1; load_val = 3'd3;
    cyc(1);
    check("ldrun0_state",  32'(state),  3);
    check("ldrun0_onehot", 32'(onehot), 8);
    load = 1'b0; run = 1'b1;

    // Asynchronous reset between edges, with tick pending
    cyc(2);
    check("arst_tick_pre", 32'(tick), 1);
    clr = 1'b0;
    #1;
    check("arst_state",   32'(state),    0);
    check("arst_state_b", 32'(state_b),  7);
    check("arst_onehot",  32'(onehot),   1);
    check("arst_tick",    32'(tick),     0);
    check("arst_wrap",    32'(wrap),     0);
    check("arst_lerr",    32'(load_err), 0);
    @(negedge clk);
    clr = 1'b1;
    cyc(1);
    check("arst_tick_lo", 32'(tick), 0);
    cyc(1);
    check("arst_tick_hi", 32'(tick), 1);
    cyc(1);
    check("arst_first_step", 32'(state), 1);

    // DIV=1, N_STATES=2: toggle every clk, wrap on each 1->0
    s2_run = 1'b1;
    #1;
    check("s2_tick", 32'(s2_tick), 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check("s2_state",  32'(s2_state),  (k % 2 == 0) ? 1 : 0);
      check("s2_wrap",   32'(s2_wrap),   (k % 2 == 0) ? 0 : 1);
      check("s2_onehot", 32'(s2_onehot), (k % 2 == 0) ? 2 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
